// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronized line, 3-sample majority vote per bit,
// optional even/odd parity, one-cycle DATA_VALID / PAR_ERR / STP_ERR pulses.
module uart_rx #(
    parameter int DATAWIDTH = 8,
    parameter int PRESC_W   = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX_IN,
    input  logic [PRESC_W-1:0]   PRESCALE,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    output logic [DATAWIDTH-1:0] P_DATA,
    output logic                 DATA_VALID,
    output logic                 PAR_ERR,
    output logic                 STP_ERR,
    output logic [2:0]           fsm_state
);

    localparam int BIT_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 armed;
    logic [PRESC_W-1:0]   edge_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [PRESC_W-1:0]   p_lat;
    logic                 par_en_lat;
    logic                 par_typ_lat;
    logic [DATAWIDTH-1:0] shift_reg;
    logic                 par_acc;
    logic                 par_mis;
    logic                 samp_0;
    logic                 samp_1;

    logic [PRESC_W-1:0]   half;
    logic [PRESC_W-1:0]   samp_lo;
    logic [PRESC_W-1:0]   samp_hi;
    logic [PRESC_W-1:0]   last_edge;
    logic                 at_res;
    logic                 at_end;
    logic                 voted;
    logic                 par_exp;

    assign half      = p_lat >> 1;
    assign samp_lo   = half - 1'b1;
    assign samp_hi   = half + 1'b1;
    assign last_edge = p_lat - 1'b1;
    assign at_res    = (edge_cnt == samp_hi);
    assign at_end    = (edge_cnt == last_edge);
    // The third sample is the live rx_s of the resolution cycle.
    assign voted     = (samp_0 & samp_1) | (samp_0 & rx_s) | (samp_1 & rx_s);
    assign par_exp   = par_typ_lat ? ~par_acc : par_acc;
    assign fsm_state = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            armed       <= 1'b0;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            p_lat       <= '0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
            shift_reg   <= '0;
            par_acc     <= 1'b0;
            par_mis     <= 1'b0;
            samp_0      <= 1'b0;
            samp_1      <= 1'b0;
            P_DATA      <= '0;
            DATA_VALID  <= 1'b0;
            PAR_ERR     <= 1'b0;
            STP_ERR     <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state != IDLE) begin
                if (edge_cnt == samp_lo) samp_0 <= rx_s;
                if (edge_cnt == half)    samp_1 <= rx_s;
                edge_cnt <= at_end ? '0 : edge_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state       <= START;
                        edge_cnt    <= '0;
                        bit_cnt     <= '0;
                        p_lat       <= PRESCALE;
                        par_en_lat  <= PAR_EN;
                        par_typ_lat <= PAR_TYP;
                        par_acc     <= 1'b0;
                        par_mis     <= 1'b0;
                    end
                end
                START: begin
                    if (at_res && voted) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (at_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (at_res) begin
                        shift_reg <= {voted, shift_reg[DATAWIDTH-1:1]};
                        par_acc   <= par_acc ^ voted;
                    end
                    if (at_end) begin
                        if (bit_cnt == BIT_W'(DATAWIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_lat ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (at_res) par_mis <= (voted != par_exp);
                    if (at_end) state <= STOP;
                end
                STOP: begin
                    // Leave half a bit early so a back-to-back start is never missed.
                    if (at_res) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        if (voted && !par_mis) begin
                            P_DATA     <= shift_reg;
                            DATA_VALID <= 1'b1;
                        end
                        if (!voted) begin
                            STP_ERR <= 1'b1;
                            armed   <= 1'b0;
                        end
                        if (par_mis) PAR_ERR <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
